fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Parametrised instruction-fetch front end for the RV32I core pipeline. Issues word requests on the req/gnt/rvalid instruction-memory handshake, allows up to MAX_OUTST requests in flight, and buffers returned {pc, instr} pairs in a DEPTH-entry FIFO. Feeds decode through a valid/ready interface. On a branch redirect it discards stale responses, so it replaces the single-entry, non-flushing fetch stage.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, prefetch FIFO entries; power of two, >=2
MAX_OUTST, 2, maximum granted-but-unanswered requests; 1..DEPTH
RESET_PC, 32'h0000_0000, first fetch address after reset; 4-byte aligned

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
instr_req_out  out  1  memory request
instr_addr_out  out  XLEN  request address, word aligned
gnt_in  in  1  memory accepted the request this cycle
instr_rvalid_in  in  1  response data valid
instr_rdata_in  in  32  response instruction word
branch_in  in  1  redirect strobe from execute (mispredict/jump)
branch_target_in  in  XLEN  redirect address; bits [1:0] ignored (forced 0)
ready_in  in  1  decode accepts the head entry
valid_out  out  1  head entry valid
instr_out  out  32  head instruction
pc_out  out  XLEN  PC of head instruction

Behaviour:
- Reset (reset=0, any time, including mid-transfer): instr_req_out=0; instr_addr_out=RESET_PC; valid_out=0; instr_out=0; pc_out=0; FIFO empty; outstanding=0; discard=0; state=BOOT.
- FSM BOOT -> RUN on the first clock edge after reset release. BOOT drives req=0. RUN stays in RUN except under reset.
- Issue condition (RUN): instr_req_out = (outstanding < MAX_OUTST) && (fifo_count + outstanding - discard < DEPTH). This credit rule guarantees the FIFO never overflows.
- While req=1 and gnt_in=0, instr_addr_out holds stable. Sole exception: a redirect.
- Handshake on req&&gnt_in: outstanding+1; the granted address is pushed into an internal PC tag queue (depth MAX_OUTST); fetch_addr += 4.
- Rollover: fetch_addr wraps modulo 2^XLEN, 0xFFFF_FFFC -> 0x0.
- Response on instr_rvalid_in:
  - outstanding-1.
  - If discard>0: data dropped, discard-1.
  - Otherwise {tag_queue head, instr_rdata_in} pushed to the FIFO.
  - Responses return in order.
- Grant and rvalid in the same cycle: outstanding is unchanged; both queues update.
- Output: valid_out = !fifo_empty. instr_out/pc_out show the FIFO head. Pop on valid_out && ready_in. Minimum latency is rvalid in cycle N -> valid_out in cycle N+1 (no combinational bypass).
- Simultaneous push and pop: always permitted, including with the FIFO full, count unchanged.
- Redirect (branch_in=1, cycle N):
  - FIFO cleared and tag queue cleared.
  - discard <= outstanding after cycle N's grant/rvalid. A grant in cycle N counts as outstanding; an rvalid in cycle N is dropped.
  - fetch_addr <= {branch_target_in[XLEN-1:2], 2'b00}.
  - valid_out=0 in cycle N+1.
  - An ungranted request in cycle N is retargeted to the new address in N+1. The memory samples the address only on gnt, so this is legal.
  - A pop in cycle N still occurs.
- Back-to-back redirects: the last one wins; discard counts accumulate correctly.
- Protocol violation: rvalid with outstanding=0 is ignored. An assertion flags it.

Decomposition:
- Shared package core_pkg: XLEN, INSTR_W=32, NOP=32'h0000_0013, typedef fetch_entry_t {pc, instr}, function align_word().
- Sub-module fetch_fifo: generic synchronous FIFO of fetch_entry_t with DEPTH, push/pop/flush, full/empty/count.
- The FSM, credit counters, tag queue and address generator remain in fetch_prefetch.

Test Plan:
1. Reset release; gnt/rvalid answer each request one cycle later; ready_in=1 -> addresses 0x0,0x4,0x8,... are issued. valid_out first rises 3 cycles after release with pc_out=0x0, instr_out=0x00100093.
2. ready_in=0, memory always grants and responds -> exactly DEPTH=4 entries are buffered, instr_req_out falls, FIFO never overflows. Raise ready_in -> PCs 0x0..0xC are delivered in order, then fetching resumes at 0x10.
3. Two requests outstanding (0x8, 0xC) when branch_in=1 with target 0x103 -> discard=2 and both responses are dropped. Next request addr=0x100; next valid_out shows pc_out=0x100.
4. gnt_in held low 5 cycles -> instr_addr_out is stable at 0x4 throughout. Grant on cycle 6 -> the address advances to 0x8 next cycle.
5. Assert reset mid-transfer with outstanding=2 and the FIFO holding 3 -> all outputs are at their reset values immediately (asynchronously). After release, fetch restarts at RESET_PC with no stale data delivered.
6. Start fetch_addr at 0xFFFF_FFF8 via branch -> issue 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. pc_out sequence matches.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the RV32I core front end.
//   XLEN          : address / PC width
//   INSTR_W       : instruction word width
//   NOP           : canonical RV32I no-op (addi x0, x0, 0)
//   fetch_entry_t : {pc, instr} pair carried from fetch to decode
//   fetch_state_e : fetch front-end FSM states
//   align_word()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_if
// Instruction-memory request/grant/response bus.
//   instr_req_out   : fetch -> memory, request valid
//   instr_addr_out  : fetch -> memory, word-aligned request address
//   gnt_in          : memory -> fetch, request accepted this cycle
//   instr_rvalid_in : memory -> fetch, response valid (in request order)
//   instr_rdata_in  : memory -> fetch, response instruction word
// Modports: master = fetch side, slave = memory side.
// -----------------------------------------------------------------------------
interface fetch_prefetch_if #(
    parameter int XLEN = 32
);
    logic            instr_req_out;
    logic [XLEN-1:0] instr_addr_out;
    logic            gnt_in;
    logic            instr_rvalid_in;
    logic [31:0]     instr_rdata_in;

    modport master (
        output instr_req_out,
        output instr_addr_out,
        input  gnt_in,
        input  instr_rvalid_in,
        input  instr_rdata_in
    );

    modport slave (
        input  instr_req_out,
        input  instr_addr_out,
        output gnt_in,
        output instr_rvalid_in,
        output instr_rdata_in
    );
endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t with flush. The head entry is visible
// combinationally on o_head so decode sees it in the cycle valid is raised.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   i_push, i_data : write an entry (accepted when not full, or full with pop)
//   i_pop          : remove the head entry (ignored when empty)
//   i_flush        : discard all entries; wins over push/pop
//   o_head         : head entry
//   o_full/o_empty : occupancy flags
//   o_count        : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  fetch_entry_t                 i_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output fetch_entry_t                 o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rp];

    assign w_pop  = i_pop && !o_empty;
    // A full FIFO can still take a push in the same cycle as a pop.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wp] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// -----------------------------------------------------------------------------
// fetch_prefetch
// Instruction-fetch front end: issues word requests with up to MAX_OUTST in
// flight, tags each grant with its address, buffers {pc, instr} responses in
// a DEPTH-entry FIFO and presents them to decode over valid/ready. A branch
// redirect flushes buffered work and drops responses still in flight.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   mem (master)      : instruction-memory req/gnt/rvalid bus
//   branch_in         : redirect strobe from execute
//   branch_target_in  : redirect address (byte offset ignored)
//   ready_in          : decode accepts the head entry
//   valid_out         : head entry valid
//   instr_out, pc_out : head instruction and its PC (zero when empty)
// XLEN must match core_pkg::XLEN because the FIFO entry type is shared.
// -----------------------------------------------------------------------------
module fetch_prefetch #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    fetch_prefetch_if.master        mem,
    input  logic                    branch_in,
    input  logic [XLEN-1:0]         branch_target_in,
    input  logic                    ready_in,
    output logic                    valid_out,
    output logic [31:0]             instr_out,
    output logic [XLEN-1:0]         pc_out
);

    import core_pkg::*;

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + MAX_OUTST + 1);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;

    logic [XLEN-1:0] r_fetch_addr;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_discard;
    logic [OW-1:0]   w_outst_next;

    logic [XLEN-1:0] r_tag [MAX_OUTST];
    logic [TW-1:0]   r_tag_wp;
    logic [TW-1:0]   r_tag_rp;

    logic            w_req;
    logic            w_credit_ok;
    logic [SW-1:0]   w_committed;
    logic            w_gnt;
    logic            w_rv;
    logic            w_drop;
    logic            w_accept;
    logic            w_pop;

    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] ptr);
        return (ptr == TW'(MAX_OUTST - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Slots already committed: buffered entries plus in-flight requests that
    // will be kept. Issuing only while this is below DEPTH means every live
    // response always finds room in the FIFO.
    assign w_committed = SW'(w_fifo_count) + SW'(r_outst - r_discard);
    assign w_credit_ok = (r_outst < OW'(MAX_OUTST)) && (w_committed < SW'(DEPTH));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  w_req        = w_credit_ok;
            default: w_state_next = ST_BOOT;
        endcase
    end

    // --------------------------------------------------- handshake decode
    assign w_gnt    = w_req && mem.gnt_in;
    // A response with nothing outstanding is a protocol error; ignore it.
    assign w_rv     = mem.instr_rvalid_in && (r_outst != '0);
    assign w_drop   = w_rv && (r_discard != '0);
    // A response arriving in the redirect cycle belongs to the old stream.
    assign w_accept = w_rv && !w_drop && !branch_in;
    assign w_pop    = valid_out && ready_in;

    assign w_outst_next = r_outst + OW'(w_gnt) - OW'(w_rv);

    // ------------------------- address generator, credits and tag queue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_addr <= RESET_PC;
            r_outst      <= '0;
            r_discard    <= '0;
            r_tag_wp     <= '0;
            r_tag_rp     <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (branch_in) begin
                // Everything still in flight after this cycle is stale,
                // including a request granted in this same cycle.
                r_fetch_addr <= align_word(branch_target_in);
                r_discard    <= w_outst_next;
                r_tag_wp     <= '0;
                r_tag_rp     <= '0;
            end else begin
                if (w_gnt) begin
                    r_fetch_addr <= r_fetch_addr + XLEN'(4);
                    r_tag_wp     <= tag_inc(r_tag_wp);
                end
                if (w_drop) begin
                    r_discard <= r_discard - 1'b1;
                end
                if (w_accept) begin
                    r_tag_rp <= tag_inc(r_tag_rp);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt && !branch_in) begin
            r_tag[r_tag_wp] <= r_fetch_addr;
        end
    end

    assign mem.instr_req_out  = w_req;
    assign mem.instr_addr_out = r_fetch_addr;

    // --------------------------------------------------------- prefetch FIFO
    assign w_push_entry.pc    = r_tag[r_tag_rp];
    assign w_push_entry.instr = mem.instr_rdata_in;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (branch_in),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign valid_out = !w_fifo_empty;
    assign instr_out = valid_out ? w_head.instr : '0;
    assign pc_out    = valid_out ? w_head.pc    : '0;

    // ------------------------------------------------------------ checks
    a_no_orphan_rvalid: assert property (
        @(posedge clk) disable iff (!reset)
        !(mem.instr_rvalid_in && (r_outst == '0)));

    a_no_fifo_overflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(w_accept && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_fetch_prefetch.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch
// Randomised memory/decode environment for fetch_prefetch. The reference
// tracks the decode-visible stream at transaction level: the PC sequence
// expected since the last redirect or reset, the granted-but-unanswered
// requests (tagged with the redirect epoch they belong to) and how many live
// responses are waiting for decode.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch;
    import core_pkg::*;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_in = 1'b0;
    logic [31:0] branch_target_in = '0;
    logic        ready_in = 1'b0;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    fetch_prefetch_if #(.XLEN(32)) mem_bus ();

    fetch_prefetch #(
        .XLEN      (32),
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem              (mem_bus),
        .branch_in        (branch_in),
        .branch_target_in (branch_target_in),
        .ready_in         (ready_in),
        .valid_out        (valid_out),
        .instr_out        (instr_out),
        .pc_out           (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
    } pend_t;

    pend_t       mem_q[$];
    logic [31:0] glog[$];
    logic [31:0] plog[$];
    int          epoch = 0;
    int          buffered = 0;
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] exp_pc = RESET_PC;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    bit          br_prev = 0;
    int          cyc = 0;
    int          total_pops = 0;

    int          n_cmp = 0;
    int          n_err = 0;

    int          p_gnt = 100, p_rv = 100, p_ready = 100, p_branch = 0;
    bit          force_br = 0;
    logic [31:0] force_tgt = '0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h0010_0093 ^ (a * 32'h9E37_79B1);
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
        return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_req",   mem_bus.instr_req_out, 1'b0);
        check("rst_addr",  mem_bus.instr_addr_out, RESET_PC);
        check("rst_valid", valid_out, 1'b0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc",    pc_out, 32'h0);
        mem_bus.gnt_in          = 1'b0;
        mem_bus.instr_rvalid_in = 1'b0;
        mem_bus.instr_rdata_in  = '0;
        branch_in               = 1'b0;
        branch_target_in        = '0;
        ready_in                = 1'b0;
        mem_q.delete();
        glog.delete();
        plog.delete();
        epoch++;
        buffered   = 0;
        exp_fetch  = RESET_PC;
        exp_pc     = RESET_PC;
        prev_stall = 0;
        br_prev    = 0;
        force_br   = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        #1;
        check("boot_req", mem_bus.instr_req_out, 1'b0);
    endtask

    // One clock cycle: sample, compare against the reference, then drive.
    task automatic cycle();
        bit          g, rv, rdy, br;
        logic [31:0] tgt;
        pend_t       h;
        int          live;

        @(negedge clk);
        cyc++;
        s_req   = mem_bus.instr_req_out;
        s_addr  = mem_bus.instr_addr_out;
        s_valid = valid_out;
        s_pc    = pc_out;
        s_instr = instr_out;

        live = 0;
        foreach (mem_q[i]) if (mem_q[i].ep == epoch) live++;

        check("req", s_req, (mem_q.size() < MAX_OUTST) && (buffered + live < DEPTH));
        check("valid", s_valid, buffered > 0);
        if (s_valid) begin
            check("head_pc", s_pc, exp_pc);
            check("head_instr", s_instr, mem_data(exp_pc));
        end
        if (br_prev)    check("valid_after_branch", s_valid, 1'b0);
        if (prev_stall) check("addr_hold", s_addr, prev_addr);
        if (s_req)      check("addr_align", s_addr[1:0], 2'b00);

        rdy = ($urandom_range(99, 0) < p_ready);
        g   = s_req && ($urandom_range(99, 0) < p_gnt);
        rv  = (mem_q.size() > 0) && ($urandom_range(99, 0) < p_rv);
        br  = force_br || ($urandom_range(99, 0) < p_branch);
        if (force_br) tgt = force_tgt;
        else if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
        else tgt = $urandom;
        force_br = 0;

        h = '{addr: 32'h0, ep: -1};
        if (rv) h = mem_q.pop_front();

        ready_in                = rdy;
        mem_bus.gnt_in          = g;
        mem_bus.instr_rvalid_in = rv;
        mem_bus.instr_rdata_in  = rv ? mem_data(h.addr) : $urandom;
        branch_in               = br;
        branch_target_in        = tgt;

        if (rv && h.ep == epoch && !br) buffered++;
        if (rdy && s_valid) begin
            $display("deliver pc=%h instr=%h cycle=%0d", exp_pc, mem_data(exp_pc), cyc);
            plog.push_back(exp_pc);
            exp_pc += 32'd4;
            buffered--;
            total_pops++;
        end
        if (g) begin
            check("grant_addr", s_addr, exp_fetch);
            glog.push_back(s_addr);
            mem_q.push_back('{addr: s_addr, ep: epoch});
            exp_fetch += 32'd4;
        end
        if (br) begin
            epoch++;
            buffered  = 0;
            exp_fetch = {tgt[31:2], 2'b00};
            exp_pc    = exp_fetch;
            glog.delete();
            plog.delete();
        end
        prev_stall = s_req && !g && !br;
        prev_addr  = s_addr;
        br_prev    = br;
    endtask

    initial begin
        int first_valid;
        logic [31:0] fv_pc, fv_instr;
        bit found;

        // 1: first delivery latency and address sequence
        do_reset();
        p_gnt = 100; p_rv = 100; p_ready = 100; p_branch = 0;
        first_valid = -1; fv_pc = '1; fv_instr = '1;
        repeat (8) begin
            cycle();
            if (first_valid < 0 && s_valid) begin
                first_valid = cyc; fv_pc = s_pc; fv_instr = s_instr;
            end
        end
        check("t1_first_valid_cycle", first_valid, 3);
        check("t1_first_pc", fv_pc, 32'h0);
        check("t1_first_instr", fv_instr, 32'h0010_0093);
        check("t1_grant2", qget(glog, 2), 32'h8);

        // 2: backpressure fills exactly DEPTH entries, then drains in order
        do_reset();
        p_ready = 0;
        repeat (12) cycle();
        check("t2_grants", glog.size(), DEPTH);
        check("t2_req_low", s_req, 1'b0);
        check("t2_valid", s_valid, 1'b1);
        p_ready = 100;
        repeat (12) cycle();
        check("t2_pop3", qget(plog, 3), 32'hC);
        check("t2_resume", qget(glog, 4), 32'h10);

        // 3: redirect with 0x8 and 0xC in flight
        do_reset();
        p_ready = 100;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (mem_q.size() == 1 && mem_q[0].addr == 32'h8) found = 1;
        end
        check("t3_setup", found, 1'b1);
        p_rv = 0;
        cycle();
        check("t3_outst", mem_q.size(), 2);
        force_br = 1; force_tgt = 32'h103;
        cycle();
        p_rv = 100;
        repeat (10) cycle();
        check("t3_next_grant", qget(glog, 0), 32'h100);
        check("t3_next_pc", qget(plog, 0), 32'h100);

        // 4: address holds while the grant is withheld
        do_reset();
        cycle();
        p_gnt = 0;
        repeat (5) begin
            cycle();
            check("t4_hold_addr", s_addr, 32'h4);
            check("t4_hold_req", s_req, 1'b1);
        end
        p_gnt = 100;
        cycle();
        cycle();
        check("t4_advance", s_addr, 32'h8);

        // 5: reset mid-transfer (do_reset checks the asynchronous values)
        p_ready = 0;
        repeat (4) cycle();
        do_reset();
        p_ready = 100;
        repeat (10) cycle();
        check("t5_restart_pc", qget(plog, 0), RESET_PC);

        // 6: address rollover
        do_reset();
        repeat (3) cycle();
        force_br = 1; force_tgt = 32'hFFFF_FFF8;
        cycle();
        repeat (12) cycle();
        check("t6_g0", qget(glog, 0), 32'hFFFF_FFF8);
        check("t6_g1", qget(glog, 1), 32'hFFFF_FFFC);
        check("t6_g2", qget(glog, 2), 32'h0);
        check("t6_p0", qget(plog, 0), 32'hFFFF_FFF8);
        check("t6_p2", qget(plog, 2), 32'h0);

        // Random traffic
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            p_gnt    = $urandom_range(100, 20);
            p_rv     = $urandom_range(100, 20);
            p_ready  = $urandom_range(100, 10);
            p_branch = 3;
            repeat (800) cycle();
        end
        p_branch = 0;
        check("liveness", total_pops > 200, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
